// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe
// Two-stage valid/ready posit packer. Takes an unpacked value
// (sign, signed power-of-two scale, fraction below the hidden one, sticky,
// zero and NaR flags) and produces a rounded WIDTH-bit posit with es = EN.
//
// Stage 1 builds the regime/exponent/fraction string and splits it into
// magnitude, guard and sticky. Stage 2 rounds to nearest-even, clamps to
// [minpos, maxpos] and applies the sign.
//
// Optional build macro: POSIT_ENC_FLAGS_EN
//   When defined, adds out_inexact and out_sat, registered with out_data.
//   The data path and latency do not depend on the macro.

module posit_encode_pipe #(
    parameter int WIDTH   = 32,
    parameter int EN      = 2,
    parameter int FRAC_W  = 32,
    parameter int SCALE_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [SCALE_W-1:0] in_scale,
    input  logic [FRAC_W-1:0]  in_frac,
    input  logic               in_sticky,
    input  logic               in_zero,
    input  logic               in_nar,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
`ifdef POSIT_ENC_FLAGS_EN
    ,
    output logic               out_inexact,
    output logic               out_sat
`endif
);

    // Magnitude excludes the sign bit.
    localparam int MAG_W = WIDTH - 1;
    // Regime seed (2 bits) + exponent + fraction + enough zero padding that
    // the largest regime shift never pushes a bit off the bottom.
    localparam int EXT_W = 2 + EN + FRAC_W + WIDTH;
    localparam int MAX_SCALE = (WIDTH - 2) * (2 ** EN);

    localparam logic signed [SCALE_W-1:0] SCALE_HI = SCALE_W'(MAX_SCALE);
    localparam logic signed [SCALE_W-1:0] SCALE_LO = SCALE_W'(-MAX_SCALE);

    localparam logic [MAG_W-1:0] MAXPOS_MAG = {MAG_W{1'b1}};
    localparam logic [MAG_W-1:0] MINPOS_MAG = {{(MAG_W-1){1'b0}}, 1'b1};
    localparam logic [MAG_W-1:0] ZERO_MAG   = {MAG_W{1'b0}};
    localparam logic [WIDTH-1:0] NAR_WORD   = {1'b1, {MAG_W{1'b0}}};
    localparam logic [WIDTH-1:0] ZERO_WORD  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_WORD   = {{(WIDTH-1){1'b0}}, 1'b1};

    // Classification carried from stage 1 into stage 2.
    typedef enum logic [2:0] {
        CLS_NORM    = 3'd0,
        CLS_ZERO    = 3'd1,
        CLS_NAR     = 3'd2,
        CLS_SAT_MAX = 3'd3,
        CLS_SAT_MIN = 3'd4
    } val_class_e;

    // Two's complement over WIDTH bits of a non-negative magnitude.
    function automatic logic [WIDTH-1:0] apply_sign(input logic neg,
                                                    input logic [MAG_W-1:0] mag);
        logic [WIDTH-1:0] word;
        word = {1'b0, mag};
        if (neg) begin
            apply_sign = (~word) + ONE_WORD;
        end else begin
            apply_sign = word;
        end
    endfunction

    // Round-to-nearest, ties-to-even increment decision.
    function automatic logic round_up(input logic guard, input logic lsb,
                                      input logic sticky);
        round_up = guard & (lsb | sticky);
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_load_s;
    logic s1_advance_s;

    // Stage-advance conditions and the upstream ready.
    always_comb begin
        s2_load_s    = !out_valid_q || out_ready;
        s1_advance_s = s1_valid_q && s2_load_s;
        in_ready     = !rst && (!s1_valid_q || s1_advance_s);
    end

    // ------------------------------------------------------------------
    // Stage 1: regime / exponent / fraction string
    // ------------------------------------------------------------------
    logic signed [SCALE_W-1:0] scale_s;
    logic signed [SCALE_W-1:0] k_s;
    logic                      k_neg_s;
    logic        [SCALE_W-1:0] shamt_s;
    logic signed [EXT_W-1:0]   ext_s;
    logic signed [EXT_W-1:0]   ext_sh_s;
    val_class_e                cls_s;
    logic        [MAG_W-1:0]   mag_s;
    logic                      guard_s;
    logic                      sticky_s;

    // Build the shifted regime string: seed "10" (k>=0) or "01" (k<0) and
    // shift arithmetically so the sign fill extends the run of equal bits.
    always_comb begin
        scale_s = $signed(in_scale);
        k_s     = scale_s >>> EN;
        k_neg_s = k_s[SCALE_W-1];
        // For k < 0 the run of zeros is -k, which needs a shift of -k-1 = ~k.
        if (k_neg_s) begin
            shamt_s = ~k_s;
        end else begin
            shamt_s = k_s;
        end
        ext_s    = {~k_neg_s, k_neg_s, in_scale[EN-1:0], in_frac, {WIDTH{1'b0}}};
        ext_sh_s = ext_s >>> shamt_s;
        mag_s    = ext_sh_s[EXT_W-1 -: MAG_W];
        guard_s  = ext_sh_s[EXT_W-1-MAG_W];
        sticky_s = (|ext_sh_s[EXT_W-2-MAG_W:0]) | in_sticky;

        if (in_nar) begin
            cls_s = CLS_NAR;
        end else if (in_zero) begin
            cls_s = CLS_ZERO;
        end else if (scale_s > SCALE_HI) begin
            cls_s = CLS_SAT_MAX;
        end else if (scale_s < SCALE_LO) begin
            cls_s = CLS_SAT_MIN;
        end else begin
            cls_s = CLS_NORM;
        end
    end

    logic       s1_sign_q,   s1_sign_d;
    val_class_e s1_cls_q,    s1_cls_d;
    logic [MAG_W-1:0] s1_mag_q, s1_mag_d;
    logic       s1_guard_q,  s1_guard_d;
    logic       s1_sticky_q, s1_sticky_d;

    // Stage-1 next state: load on accept, empty when advancing, else hold.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_cls_d    = s1_cls_q;
        s1_mag_d    = s1_mag_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        if (in_valid && in_ready) begin
            s1_valid_d  = 1'b1;
            s1_sign_d   = in_sign;
            s1_cls_d    = cls_s;
            s1_mag_d    = mag_s;
            s1_guard_d  = guard_s;
            s1_sticky_d = sticky_s;
        end else if (s1_advance_s) begin
            s1_valid_d  = 1'b0;
        end else begin
            s1_valid_d  = s1_valid_q;
        end
    end

    // Stage-1 register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_cls_q    <= CLS_ZERO;
            s1_mag_q    <= ZERO_MAG;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_cls_q    <= s1_cls_d;
            s1_mag_q    <= s1_mag_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, clamp, sign, pack
    // ------------------------------------------------------------------
    logic             rnd_up_s;
    logic [WIDTH-1:0] mag_rnd_s;
    logic [MAG_W-1:0] mag_fin_s;
    logic [WIDTH-1:0] packed_s;

    // Rounding carries ripple into exponent/regime naturally; a carry into
    // bit MAG_W means past maxpos and is clamped, never reaching the sign.
    always_comb begin
        rnd_up_s  = round_up(s1_guard_q, s1_mag_q[0], s1_sticky_q);
        mag_rnd_s = {1'b0, s1_mag_q} + {{MAG_W{1'b0}}, rnd_up_s};
        if (mag_rnd_s[WIDTH-1]) begin
            mag_fin_s = MAXPOS_MAG;
        end else if (mag_rnd_s[MAG_W-1:0] == ZERO_MAG) begin
            mag_fin_s = MINPOS_MAG;
        end else begin
            mag_fin_s = mag_rnd_s[MAG_W-1:0];
        end

        case (s1_cls_q)
            CLS_NAR:     packed_s = NAR_WORD;
            CLS_ZERO:    packed_s = ZERO_WORD;
            CLS_SAT_MAX: packed_s = apply_sign(s1_sign_q, MAXPOS_MAG);
            CLS_SAT_MIN: packed_s = apply_sign(s1_sign_q, MINPOS_MAG);
            CLS_NORM:    packed_s = apply_sign(s1_sign_q, mag_fin_s);
            default:     packed_s = ZERO_WORD;
        endcase
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;

    // Output-stage next state: refill when empty or consumed, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (s2_load_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = packed_s;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= ZERO_WORD;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef POSIT_ENC_FLAGS_EN
    logic inexact_s, sat_s;
    logic out_inexact_q, out_inexact_d;
    logic out_sat_q, out_sat_d;

    // Status flags for the beat in stage 1; specials report neither flag.
    always_comb begin
        case (s1_cls_q)
            CLS_NORM: begin
                inexact_s = s1_guard_q | s1_sticky_q;
                sat_s     = mag_rnd_s[WIDTH-1] || (mag_rnd_s[MAG_W-1:0] == ZERO_MAG);
            end
            CLS_SAT_MAX, CLS_SAT_MIN: begin
                inexact_s = 1'b1;
                sat_s     = 1'b1;
            end
            default: begin
                inexact_s = 1'b0;
                sat_s     = 1'b0;
            end
        endcase
    end

    // Flag next state follows the same load/hold rule as out_data.
    always_comb begin
        out_inexact_d = out_inexact_q;
        out_sat_d     = out_sat_q;
        if (s2_load_s && s1_valid_q) begin
            out_inexact_d = inexact_s;
            out_sat_d     = sat_s;
        end else begin
            out_inexact_d = out_inexact_q;
            out_sat_d     = out_sat_q;
        end
    end

    // Flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_inexact_q <= 1'b0;
            out_sat_q     <= 1'b0;
        end else begin
            out_inexact_q <= out_inexact_d;
            out_sat_q     <= out_sat_d;
        end
    end

    assign out_inexact = out_inexact_q;
    assign out_sat     = out_sat_q;
`endif

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed bench for posit_encode_pipe with a scoreboard queue: expected
// words are pushed when a beat is accepted and popped when it emerges.
// Flags are checked only when POSIT_ENC_FLAGS_EN is defined.

module tb_posit_encode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_scale;
    logic [31:0] in_frac;
    logic        in_sticky;
    logic        in_zero;
    logic        in_nar;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef POSIT_ENC_FLAGS_EN
    logic        out_inexact;
    logic        out_sat;
`endif

    always #5 clk = ~clk;

    posit_encode_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .in_sticky (in_sticky),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef POSIT_ENC_FLAGS_EN
        ,
        .out_inexact (out_inexact),
        .out_sat     (out_sat)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        inx;
        logic        sat;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   beat   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Scoreboard monitor: compare every output handshake against the queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty_on_output", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("beat%0d_data", beat), out_data, e.data);
`ifdef POSIT_ENC_FLAGS_EN
                chk($sformatf("beat%0d_inexact", beat), {31'd0, out_inexact}, {31'd0, e.inx});
                chk($sformatf("beat%0d_sat", beat), {31'd0, out_sat}, {31'd0, e.sat});
`endif
                if (e.lat) chk($sformatf("beat%0d_latency", beat), 32'(cyc - e.acc), 32'd2);
                pop_cyc.push_back(cyc);
                beat++;
            end
        end
    end

    // Drive one beat and wait (bounded) for it to be accepted.
    task automatic send(input logic sg, input logic [8:0] sc, input logic [31:0] fr,
                        input logic st, input logic zr, input logic nr,
                        input logic [31:0] ed, input logic ei, input logic es,
                        input bit lat);
        exp_t e;
        bit   got;
        in_valid  = 1'b1;
        in_sign   = sg;
        in_scale  = sc;
        in_frac   = fr;
        in_sticky = st;
        in_zero   = zr;
        in_nar    = nr;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = ed; e.inx = ei; e.sat = es; e.acc = cyc; e.lat = lat;
                sb.push_back(e);
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_scale = 9'd0;
        in_frac = 32'd0; in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0000_0000);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic encodings, back-to-back, latency checked
        send(1'b0, 9'd0,   32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
        send(1'b1, 9'd0,   32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'hC000_0000, 1'b0, 1'b0, 1'b1);
        send(1'b0, 9'd1,   32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4800_0000, 1'b0, 1'b0, 1'b1);
        send(1'b0, 9'd0,   32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h4400_0000, 1'b0, 1'b0, 1'b1);
        send(1'b0, 9'h1FF, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h3800_0000, 1'b0, 1'b0, 1'b1);
        send(1'b0, 9'h1FB, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h1C00_0000, 1'b0, 1'b0, 1'b1);
        // Rounding
        send(1'b0, 9'd0,   32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b1, 1'b0, 1'b1);
        send(1'b0, 9'd0,   32'h0000_0030, 1'b0, 1'b0, 1'b0, 32'h4000_0002, 1'b1, 1'b0, 1'b1);
        send(1'b0, 9'd0,   32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h4000_0001, 1'b1, 1'b0, 1'b1);
        send(1'b1, 9'd0,   32'h0000_0030, 1'b0, 1'b0, 1'b0, 32'hBFFF_FFFE, 1'b1, 1'b0, 1'b1);
        send(1'b0, 9'd3,   32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h6000_0000, 1'b1, 1'b0, 1'b1);
        // Range edges and saturation
        send(1'b0, 9'd120, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        send(1'b0, 9'h188, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(1'b0, 9'd121, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
        send(1'b0, 9'h17E, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
        send(1'b1, 9'h17E, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        // Specials
        send(1'b1, 9'd5,   32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        send(1'b1, 9'd5,   32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: six stalled cycles, only two beats may enter
        out_ready = 1'b0;
        send(1'b0, 9'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        send(1'b0, 9'd1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4800_0000, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_sign = 1'b0; in_scale = 9'd0; in_frac = 32'h8000_0000;
        in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_out_data", i), out_data, 32'h4000_0000);
            @(posedge clk); #1;
        end
        pop_cyc.delete();
        out_ready = 1'b1;
        send(1'b0, 9'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h4400_0000, 1'b0, 1'b0, 1'b0);
        drain();
        chk("bp_pop_count", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() >= 3) begin
            chk("bp_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
            chk("bp_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        end

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(1'b0, 9'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        send(1'b0, 9'd1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4800_0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", out_data, 32'h0000_0000);
        chk("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
`ifdef POSIT_ENC_FLAGS_EN
        chk("midrst_out_sat", {31'd0, out_sat}, 32'd0);
        chk("midrst_out_inexact", {31'd0, out_inexact}, 32'd0);
`endif
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1'b0, 9'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h4400_0000, 1'b0, 1'b0, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
